vreg_gather_scatter: RTL and testbench
======================================

Name: vreg_gather_scatter

Overview:
- Multi-cycle sequencer that moves data between the scalar register file and the vector register file.
- Generalises the fixed 4-lane LDV_W pack into a parametrised engine:
  - gather (LDV): LANES scalar registers are packed into one vector register;
  - scatter (STV): one vector register is unpacked into LANES scalar registers.
- Register indices follow a configurable stride.
- Sits beside REG/VREG in cpu; the control unit stalls PC advance while busy=1.

Parameters:
- LANES, 4, number of elements per vector (>=2).
- ELEM_W, 32, element width in bits.
- RADDR_W, 5, scalar/vector register index width (register count 2**RADDR_W).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse, sampled only in IDLE.
- op  in  1  0 = gather (LDV), 1 = scatter (STV).
- base  in  RADDR_W  first scalar register index ($s).
- stride  in  RADDR_W  index increment between lanes.
- vaddr  in  RADDR_W  vector register index ($d for gather, source for scatter).
- vsrc_data  in  LANES*ELEM_W  vector read data for vaddr (async read from VREG).
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle completion pulse.
- rd_addr  out  RADDR_W  scalar read index.
- rd_data  in  ELEM_W  scalar read data (async, same-cycle).
- sw_en  out  1  scalar write enable.
- sw_addr  out  RADDR_W  scalar write index.
- sw_data  out  ELEM_W  scalar write data.
- vw_en  out  1  vector write enable.
- vw_addr  out  RADDR_W  vector write index.
- vw_data  out  LANES*ELEM_W  packed vector write data.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous, active-low on rst_n.
  - While reset is asserted: state=IDLE, lane counter=0, lane buffer=0, all outputs 0.
- States: IDLE, GATHER, WRITE, SCATTER.
- IDLE:
  - start=1 at a clk edge latches op, base, stride and vaddr. Scatter also latches vsrc_data.
  - op=0 moves to GATHER; op=1 moves to SCATTER. The lane counter k is cleared in both cases.
  - start outside IDLE is ignored; it is neither queued nor allowed to corrupt latched operands.
- Lane index:
  - idx(k) = (base + k*stride) mod 2**RADDR_W, computed with RADDR_W-bit wrap-around.
  - Register 0 gets no special treatment here; the register files handle $0 semantics.
- GATHER (LANES cycles):
  - rd_addr=idx(k).
  - At the edge, rd_data is captured into lane k and k increments.
  - After k=LANES-1, move to WRITE.
- WRITE (1 cycle):
  - vw_en=1, vw_addr=latched vaddr, vw_data=lane buffer, done=1.
  - Next state is IDLE.
- Lane packing:
  - Lane 0 (from base) occupies the MSB slice [LANES*ELEM_W-1 -: ELEM_W].
  - Lane LANES-1 occupies the LSB slice.
  - This matches {$s,$s+1,$s+2,$s+3}.
- SCATTER (LANES cycles):
  - sw_en=1, sw_addr=idx(k), sw_data=latched lane k (same MSB-first order).
  - done=1 on the k=LANES-1 cycle, then IDLE.
- Latency:
  - Gather: vw_en/done in cycle LANES+1 after the start edge; busy for LANES+1 cycles.
  - Scatter: done in cycle LANES; busy for LANES cycles.
- Aliasing:
  - A stride that repeats indices (e.g. stride=0) is legal.
  - Gather duplicates the value.
  - Scatter writes in lane order, so the last lane wins.
- Outputs:
  - All outputs are registered-state decodes. No output depends combinationally on start.
  - rd_addr=0 in IDLE.
- Reset mid-operation aborts immediately:
  - no vw_en or sw_en is produced afterwards;
  - the partially filled buffer is cleared.

Optional Feature:
- Macro VGS_STRIDE_EN.
- Defined: the stride port is honoured as above.
- Undefined:
  - stride is ignored and treated as 1 (consecutive registers, the original LDV_W behaviour);
  - the stride multiplier logic is removed;
  - the port remains present for interface stability.

Decomposition:
- Shared package vgs_pkg holds:
  - state encoding typedef (IDLE=2'd0, GATHER=2'd1, WRITE=2'd2, SCATTER=2'd3);
  - op encodings VGS_OP_GATHER=1'b0 and VGS_OP_SCATTER=1'b1;
  - LDV/STV funct constants shared with the decoder.
- One natural sub-module, vgs_lane_buffer: LANES x ELEM_W storage with per-lane write, packed read, and bulk load for scatter.

Test Plan:
- Gather, base=8, stride=1, regs 8..11=10,20,30,40, vaddr=1 -> vw_en and done high exactly 5 cycles after start; vw_addr=1; vw_data={32'd10,32'd20,32'd30,32'd40}; busy high 5 cycles.
- Gather wrap, base=30, stride=1 (VGS_STRIDE_EN either way) -> rd_addr sequence 30,31,0,1; vw_data lanes = values of those registers in that order.
- Stride, base=2, stride=3 with VGS_STRIDE_EN -> rd_addr 2,5,8,11; without the macro -> 2,3,4,5.
- Scatter, vsrc_data={32'hA,32'hB,32'hC,32'hD}, base=20 -> sw_en for 4 cycles, (20,A),(21,B),(22,C),(23,D); done on 4th cycle.
- start pulsed during busy with different base -> ignored; the original transfer completes unchanged and no second transfer occurs.
- rst_n low during 2nd GATHER cycle -> busy, vw_en, sw_en and done drop immediately; after release, IDLE and a fresh gather yields correct data with no stale lanes.

Source files
------------

// File: rtl/vgs_pkg.sv
// Shared encodings for the vector gather/scatter sequencer.
// Also holds the LDV/STV funct constants used by the decoder.
package vgs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATHER  = 2'd1,
        WRITE   = 2'd2,
        SCATTER = 2'd3
    } vgs_state_t;

    localparam logic VGS_OP_GATHER  = 1'b0;
    localparam logic VGS_OP_SCATTER = 1'b1;

    localparam logic [5:0] VGS_FUNCT_LDV = 6'h2c;
    localparam logic [5:0] VGS_FUNCT_STV = 6'h2d;

endpackage

// File: rtl/vgs_lane_buffer.sv
// LANES x ELEM_W lane store: per-lane write, packed read, bulk load.
// Lane 0 sits in the most significant slice.
module vgs_lane_buffer #(
    parameter int LANES  = 4,
    parameter int ELEM_W = 32,
    parameter int KW     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [KW-1:0]           lane,
    input  logic [ELEM_W-1:0]       wr_data,
    input  logic                    load_en,
    input  logic [LANES*ELEM_W-1:0] load_data,
    output logic [LANES*ELEM_W-1:0] packed_data,
    output logic [ELEM_W-1:0]       lane_data
);

    logic [LANES*ELEM_W-1:0] data_q;
    int                      slot;

    assign slot        = (LANES - 1 - int'(lane)) * ELEM_W;
    assign packed_data = data_q;
    assign lane_data   = data_q[slot +: ELEM_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_en) begin
            data_q <= load_data;
        end else if (wr_en) begin
            data_q[slot +: ELEM_W] <= wr_data;
        end
    end

endmodule

// File: rtl/vreg_gather_scatter.sv
// Scalar<->vector register gather/scatter sequencer.
// VGS_STRIDE_EN honours the stride port; otherwise lanes are consecutive.
module vreg_gather_scatter
    import vgs_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int ELEM_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    op,
    input  logic [RADDR_W-1:0]      base,
    input  logic [RADDR_W-1:0]      stride,
    input  logic [RADDR_W-1:0]      vaddr,
    input  logic [LANES*ELEM_W-1:0] vsrc_data,
    output logic                    busy,
    output logic                    done,
    output logic [RADDR_W-1:0]      rd_addr,
    input  logic [ELEM_W-1:0]       rd_data,
    output logic                    sw_en,
    output logic [RADDR_W-1:0]      sw_addr,
    output logic [ELEM_W-1:0]       sw_data,
    output logic                    vw_en,
    output logic [RADDR_W-1:0]      vw_addr,
    output logic [LANES*ELEM_W-1:0] vw_data
);

    localparam int            KW     = $clog2(LANES);
    localparam logic [KW-1:0] K_LAST = KW'(LANES - 1);

    vgs_state_t                state, state_n;
    logic [KW-1:0]             k;
    logic [RADDR_W-1:0]        idx;
    logic [RADDR_W-1:0]        vaddr_q;
    logic [RADDR_W-1:0]        step;
    logic                      buf_wr;
    logic                      buf_load;
    logic [LANES*ELEM_W-1:0]   buf_packed;
    logic [ELEM_W-1:0]         buf_lane;

`ifdef VGS_STRIDE_EN
    logic [RADDR_W-1:0] stride_q;
    assign step = stride_q;
`else
    logic unused_stride;
    assign unused_stride = ^stride;
    assign step          = RADDR_W'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // idx accumulates the stride, so idx(k) = base + k*stride with wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            idx     <= '0;
            vaddr_q <= '0;
`ifdef VGS_STRIDE_EN
            stride_q <= '0;
`endif
        end else if (state == IDLE) begin
            if (start) begin
                k       <= '0;
                idx     <= base;
                vaddr_q <= vaddr;
`ifdef VGS_STRIDE_EN
                stride_q <= stride;
`endif
            end
        end else if (state == GATHER || state == SCATTER) begin
            k   <= k + KW'(1);
            idx <= idx + step;
        end
    end

    always_comb begin
        state_n  = state;
        busy     = 1'b0;
        done     = 1'b0;
        rd_addr  = '0;
        sw_en    = 1'b0;
        sw_addr  = '0;
        sw_data  = '0;
        vw_en    = 1'b0;
        vw_addr  = '0;
        vw_data  = '0;
        buf_wr   = 1'b0;
        buf_load = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    buf_load = (op == VGS_OP_SCATTER);
                    state_n  = (op == VGS_OP_SCATTER) ? SCATTER : GATHER;
                end
            end
            GATHER: begin
                busy    = 1'b1;
                rd_addr = idx;
                buf_wr  = 1'b1;
                if (k == K_LAST) state_n = WRITE;
            end
            WRITE: begin
                busy    = 1'b1;
                done    = 1'b1;
                vw_en   = 1'b1;
                vw_addr = vaddr_q;
                vw_data = buf_packed;
                state_n = IDLE;
            end
            SCATTER: begin
                busy    = 1'b1;
                sw_en   = 1'b1;
                sw_addr = idx;
                sw_data = buf_lane;
                if (k == K_LAST) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    vgs_lane_buffer #(
        .LANES  (LANES),
        .ELEM_W (ELEM_W),
        .KW     (KW)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (buf_wr),
        .lane        (k),
        .wr_data     (rd_data),
        .load_en     (buf_load),
        .load_data   (vsrc_data),
        .packed_data (buf_packed),
        .lane_data   (buf_lane)
    );

endmodule

// File: tb/tb_vreg_gather_scatter.sv
// Self-checking bench for vreg_gather_scatter (LANES=4, ELEM_W=32).
module tb_vreg_gather_scatter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [4:0]   base = '0;
    logic [4:0]   stride = '0;
    logic [4:0]   vaddr = '0;
    logic [127:0] vsrc_data = '0;
    logic         busy, done, sw_en, vw_en;
    logic [4:0]   rd_addr, sw_addr, vw_addr;
    logic [31:0]  rd_data, sw_data;
    logic [127:0] vw_data;

    logic [31:0]  regs [32];
    assign rd_data = regs[rd_addr];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vreg_gather_scatter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .base(base),
        .stride(stride), .vaddr(vaddr), .vsrc_data(vsrc_data),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .sw_en(sw_en), .sw_addr(sw_addr), .sw_data(sw_data),
        .vw_en(vw_en), .vw_addr(vw_addr), .vw_data(vw_data)
    );

    typedef struct {
        logic         op;
        logic [4:0]   base;
        logic [4:0]   stride;
        logic [4:0]   vaddr;
        logic [127:0] vsrc;
        logic [19:0]  idx;
        logic [127:0] data;
    } vec_t;

    typedef struct {
        logic [19:0]  idx;
        logic [127:0] data;
        int           lat;
        int           nbusy;
        int           nvw;
        int           nsw;
        logic [4:0]   vaddr;
    } obs_t;

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: idx(k) = (base + k*step) mod 32, lane 0 in the MSB slot
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   st;
        r = v;
`ifdef VGS_STRIDE_EN
        st = int'(v.stride);
`else
        st = 1;
`endif
        for (int k = 0; k < 4; k++) begin
            logic [4:0] ix;
            ix = 5'((int'(v.base) + k * st) % 32);
            r.idx[(3-k)*5 +: 5] = ix;
            if (v.op) r.data[(3-k)*32 +: 32] = v.vsrc[(3-k)*32 +: 32];
            else      r.data[(3-k)*32 +: 32] = regs[ix];
        end
        return r;
    endfunction

    task automatic run(input vec_t v, input bit hijack, output obs_t o);
        int ng;
        int ns;
        ng = 0;
        ns = 0;
        o.idx = '0; o.data = '0; o.lat = -1;
        o.nbusy = 0; o.nvw = 0; o.nsw = 0; o.vaddr = '0;
        @(negedge clk);
        start = 1'b1; op = v.op; base = v.base; stride = v.stride;
        vaddr = v.vaddr; vsrc_data = v.vsrc;
        @(negedge clk);
        start = 1'b0; op = 1'($urandom); base = 5'($urandom);
        stride = 5'($urandom); vaddr = 5'($urandom);
        vsrc_data = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 1; c <= 12; c++) begin
            if (hijack && c == 2) begin
                start = 1'b1; op = 1'b1; base = 5'd20; vaddr = 5'd17;
            end
            if (hijack && c == 3) start = 1'b0;
            if (busy) o.nbusy++;
            if (busy && !vw_en && !sw_en) begin
                if (ng < 4) o.idx[(3-ng)*5 +: 5] = rd_addr;
                ng++;
            end
            if (sw_en) begin
                if (ns < 4) begin
                    o.idx[(3-ns)*5 +: 5]   = sw_addr;
                    o.data[(3-ns)*32 +: 32] = sw_data;
                end
                regs[sw_addr] = sw_data;
                ns++;
            end
            if (vw_en) begin
                o.nvw++;
                o.data  = vw_data;
                o.vaddr = vw_addr;
            end
            if (done && o.lat < 0) o.lat = c;
            @(negedge clk);
        end
        o.nsw = ns;
    endtask

    task automatic verify(input string tag, input vec_t e, input obs_t o);
        chk({tag, ".latency"}, 128'(o.lat), e.op ? 128'd4 : 128'd5);
        chk({tag, ".busy_cycles"}, 128'(o.nbusy), e.op ? 128'd4 : 128'd5);
        chk({tag, ".idx_seq"}, 128'(o.idx), 128'(e.idx));
        chk({tag, ".data"}, o.data, e.data);
        chk({tag, ".vw_count"}, 128'(o.nvw), e.op ? 128'd0 : 128'd1);
        chk({tag, ".sw_count"}, 128'(o.nsw), e.op ? 128'd4 : 128'd0);
        if (!e.op) chk({tag, ".vw_addr"}, 128'(o.vaddr), 128'(e.vaddr));
    endtask

    vec_t tbl [5];
    vec_t v;
    vec_t e;
    obs_t o;
    logic [31:0] exp_regs [32];
    int bad;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
        regs[8] = 32'd10; regs[9] = 32'd20; regs[10] = 32'd30; regs[11] = 32'd40;

        tbl[0] = '{1'b0, 5'd8, 5'd1, 5'd1, 128'd0,
                   {5'd8, 5'd9, 5'd10, 5'd11},
                   {32'd10, 32'd20, 32'd30, 32'd40}};
        tbl[1] = '{1'b0, 5'd30, 5'd1, 5'd7, 128'd0,
                   {5'd30, 5'd31, 5'd0, 5'd1},
                   {32'h11e, 32'h11f, 32'h100, 32'h101}};
`ifdef VGS_STRIDE_EN
        tbl[2] = '{1'b0, 5'd2, 5'd3, 5'd3, 128'd0,
                   {5'd2, 5'd5, 5'd8, 5'd11},
                   {32'h102, 32'h105, 32'd10, 32'd40}};
`else
        tbl[2] = '{1'b0, 5'd2, 5'd3, 5'd3, 128'd0,
                   {5'd2, 5'd3, 5'd4, 5'd5},
                   {32'h102, 32'h103, 32'h104, 32'h105}};
`endif
        tbl[3] = '{1'b1, 5'd20, 5'd1, 5'd5,
                   {32'hA, 32'hB, 32'hC, 32'hD},
                   {5'd20, 5'd21, 5'd22, 5'd23},
                   {32'hA, 32'hB, 32'hC, 32'hD}};
        tbl[4] = '{1'b0, 5'd20, 5'd1, 5'd9, 128'd0,
                   {5'd20, 5'd21, 5'd22, 5'd23},
                   {32'hA, 32'hB, 32'hC, 32'hD}};

        repeat (2) @(negedge clk);
        chk("reset.ctrl", 128'({busy, done, vw_en, sw_en}), 128'd0);
        chk("reset.addr", 128'({rd_addr, sw_addr, vw_addr}), 128'd0);
        chk("reset.data", vw_data | 128'(sw_data), 128'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run(tbl[i], 1'b0, o);
            verify($sformatf("vec%0d", i), tbl[i], o);
        end

        run(tbl[0], 1'b1, o);
        verify("busy_start", tbl[0], o);

        // Reset during the second gather cycle
        @(negedge clk);
        start = 1'b1; op = 1'b0; base = 5'd8; vaddr = 5'd2; stride = 5'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midrst.busy_before", 128'(busy), 128'd1);
        #1 rst_n = 1'b0;
        #1 chk("midrst.drop", 128'({busy, vw_en, sw_en, done, rd_addr}), 128'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || vw_en || sw_en || done) bad++;
        end
        chk("midrst.quiet", 128'(bad), 128'd0);
        rst_n = 1'b1;
        v = '{1'b0, 5'd30, 5'd1, 5'd4, 128'd0, 20'd0, 128'd0};
        e = model(v);
        run(v, 1'b0, o);
        verify("midrst.fresh", e, o);

        for (int i = 0; i < 24; i++) begin
            v.op     = 1'($urandom);
            v.base   = 5'($urandom);
            v.stride = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            v.vaddr  = 5'($urandom);
            v.vsrc   = {$urandom, $urandom, $urandom, $urandom};
            e = model(v);
            exp_regs = regs;
            if (v.op)
                for (int k = 0; k < 4; k++)
                    exp_regs[e.idx[(3-k)*5 +: 5]] = e.data[(3-k)*32 +: 32];
            run(v, 1'b0, o);
            verify($sformatf("rand%0d", i), e, o);
            bad = 0;
            for (int r = 0; r < 32; r++)
                if (regs[r] !== exp_regs[r]) bad++;
            chk($sformatf("rand%0d.regfile", i), 128'(bad), 128'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
